// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared constants and FSM state type for the GCD engine
package gcd_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_BUS_W  = 8;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_e;

endpackage

// File: rtl/gcd_stein_core.sv
// rtl/gcd_stein_core.sv - binary GCD datapath: a/b/k registers and one step per cycle
module gcd_stein_core #(
    parameter int DATA_W = 16,
    parameter int K_W    = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_a,
    input  logic [DATA_W-1:0] load_b,
    input  logic              step,
    output logic              zero,
    output logic              equal,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [K_W-1:0]    k_q, k_d;

    assign zero   = (a_q == '0) || (b_q == '0);
    assign equal  = (a_q == b_q);
    // The common power of two never exceeds either operand, so the shift cannot overflow.
    assign result = a_q << k_q;

    // Next operand values: load, or one Stein step. The difference of two odd values
    // is always even, so it is halved in the same cycle to keep latency bounded.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        k_d = k_q;
        if (load) begin
            a_d = load_a;
            b_d = load_b;
            k_d = '0;
        end else if (step && !zero && !equal) begin
            case ({a_q[0], b_q[0]})
                2'b00: begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + K_W'(1);
                end
                2'b01:   a_d = a_q >> 1;
                2'b10:   b_d = b_q >> 1;
                default: begin
                    if (a_q > b_q) a_d = (a_q - b_q) >> 1;
                    else           b_d = (b_q - a_q) >> 1;
                end
            endcase
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            k_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            k_q <= k_d;
        end
    end

endmodule

// File: rtl/gcd_engine_p.sv
// rtl/gcd_engine_p.sv - beat-serial GCD engine: loader, control FSM and result unloader
module gcd_engine_p
    import gcd_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int BUS_W  = DEF_BUS_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [BUS_W-1:0] A,
    input  logic [BUS_W-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [BUS_W-1:0] Y,
    output logic             ERROR
);

    localparam int BEATS = DATA_W / BUS_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [BUS_W-1:0]  y_q, y_d;

    logic [DATA_W-1:0] opa_shift, opb_shift;
    logic [DATA_W-1:0] core_result, out_val;
    logic              core_load, core_step, core_zero, core_equal;

    assign opa_shift = (opa_q << BUS_W) | DATA_W'(A);
    assign opb_shift = (opb_q << BUS_W) | DATA_W'(B);
    assign out_val   = core_zero ? '0 : core_result;

    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign Y     = y_q;
    assign ERROR = err_q;

    gcd_stein_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .clk    (CLK),
        .rst    (RST),
        .load   (core_load),
        .load_a (opa_shift),
        .load_b (opb_shift),
        .step   (core_step),
        .zero   (core_zero),
        .equal  (core_equal),
        .result (core_result)
    );

    // Control FSM: capture beats, drive the core, then stream the result MS beat first.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        res_d     = res_q;
        err_d     = err_q;
        busy_d    = busy_q;
        done_d    = done_q;
        y_d       = y_q;
        core_load = 1'b0;
        core_step = 1'b0;
        case (state_q)
            LOAD: begin
                if (START) begin
                    opa_d = opa_shift;
                    opb_d = opb_shift;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d     = '0;
                        state_d   = CALC;
                        busy_d    = 1'b1;
                        core_load = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            CALC: begin
                if (core_zero || core_equal) begin
                    state_d = OUT;
                    err_d   = core_zero;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    y_d     = out_val[DATA_W-1 -: BUS_W];
                    res_d   = out_val << BUS_W;
                end else begin
                    core_step = 1'b1;
                end
            end
            OUT: begin
                if (cnt_q == LAST_BEAT) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    y_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    y_d   = res_q[DATA_W-1 -: BUS_W];
                    res_d = res_q << BUS_W;
                end
            end
            default: begin
                state_d = LOAD;
                cnt_d   = '0;
            end
        endcase
    end

    // State, operand, result and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            y_q     <= y_d;
        end
    end

endmodule

// File: tb/tb_gcd_engine_p.sv
// tb/tb_gcd_engine_p.sv - directed self-checking bench for gcd_engine_p
module tb_gcd_engine_p;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic       BUSY, DONE, ERROR;
    logic [7:0] Y;

    int checks = 0;
    int errors = 0;

    gcd_engine_p #(.DATA_W(16), .BUS_W(8)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .A     (A),
        .B     (B),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .Y     (Y),
        .ERROR (ERROR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the edge that took the last beat.
    task automatic load_op(input logic [15:0] a, input logic [15:0] b, input int gap);
        for (int i = 0; i < 2; i++) begin
            START = 1'b1;
            A = a[15 - 8*i -: 8];
            B = b[15 - 8*i -: 8];
            @(negedge CLK);
            if (i == 0) begin
                START = 1'b0;
                A = '0;
                B = '0;
                repeat (gap) @(negedge CLK);
            end
        end
        START = 1'b0;
        A = '0;
        B = '0;
    endtask

    // n counts negedges since the final load beat (1 = first one after it).
    task automatic expect_result(input string tag, input logic [15:0] exp_y, input logic exp_err,
                                 input int max_lat, input int n0);
        int n = n0;
        check({tag, ":busy"}, BUSY, 1);
        while (!DONE && n < max_lat) begin
            @(negedge CLK);
            n++;
        end
        check({tag, ":done_in_time"}, DONE, 1);
        check({tag, ":y_hi"}, Y, exp_y[15:8]);
        check({tag, ":err0"}, ERROR, exp_err);
        @(negedge CLK);
        check({tag, ":done1"}, DONE, 1);
        check({tag, ":y_lo"}, Y, exp_y[7:0]);
        check({tag, ":err1"}, ERROR, exp_err);
        @(negedge CLK);
        check({tag, ":done_end"}, DONE, 0);
        check({tag, ":busy_end"}, BUSY, 0);
        check({tag, ":y_idle"}, Y, 0);
        check({tag, ":err_idle"}, ERROR, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_done;
        repeat (3) @(negedge CLK);
        check("rst:busy", BUSY, 0);
        check("rst:done", DONE, 0);
        check("rst:y", Y, 0);
        check("rst:err", ERROR, 0);
        RST = 1'b0;

        load_op(16'h0400, 16'h2000, 3);
        expect_result("1024_8192", 16'h0400, 1'b0, 34, 1);

        load_op(16'h0206, 16'h0103, 0);
        expect_result("518_259", 16'h0103, 1'b0, 34, 1);
        load_op(16'h0103, 16'h0000, 0);
        expect_result("259_0", 16'h0000, 1'b1, 3, 1);

        load_op(16'h0000, 16'h0000, 2);
        expect_result("0_0", 16'h0000, 1'b1, 3, 1);
        load_op(16'h0000, 16'h0103, 0);
        expect_result("0_259", 16'h0000, 1'b1, 3, 1);

        load_op(16'd46368, 16'd28657, 0);
        expect_result("fib", 16'h0001, 1'b0, 34, 1);
        load_op(16'd9487, 16'd9487, 1);
        expect_result("9487_eq", 16'h250F, 1'b0, 34, 1);

        load_op(16'h8000, 16'h4000, 0);
        expect_result("pow2", 16'h4000, 1'b0, 34, 1);
        load_op(16'hFFFF, 16'h0001, 0);
        expect_result("ffff_1", 16'h0001, 1'b0, 34, 1);
        load_op(16'hFFFF, 16'hFFFF, 0);
        expect_result("ffff_eq", 16'hFFFF, 1'b0, 34, 1);

        // START with FFh beats while computing gcd(48,18) must not disturb it
        load_op(16'd48, 16'd18, 0);
        START = 1'b1;
        A = 8'hFF;
        B = 8'hFF;
        @(negedge CLK);
        @(negedge CLK);
        START = 1'b0;
        A = '0;
        B = '0;
        expect_result("start_in_calc", 16'h0006, 1'b0, 34, 3);

        // reset after the first beat discards the partial operand
        START = 1'b1;
        A = 8'h12;
        B = 8'h34;
        @(negedge CLK);
        START = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("midrst:busy", BUSY, 0);
        seen_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (DONE) seen_done = 1;
        end
        check("midrst:no_done", seen_done, 0);
        load_op(16'd9487, 16'd9487, 0);
        expect_result("after_rst", 16'h250F, 1'b0, 34, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gcd_engine_p.md
GCD_ENGINE_P -- requirements
Module: gcd_engine_p

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter BUS_W, default 8, giving the load/unload bus width; DATA_W SHALL be an integer multiple of BUS_W, with BEATS = DATA_W/BUS_W.
REQ-003 CLK  input  1  single clock; all logic on rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 START  input  1  marks a valid load beat on A/B.
REQ-006 A  input  BUS_W  operand A beat, most-significant beat first.
REQ-007 B  input  BUS_W  operand B beat, most-significant beat first.
REQ-008 BUSY  output  1  high from the cycle after the final load beat until the last output beat.
REQ-009 DONE  output  1  high for each of the BEATS result cycles.
REQ-010 Y  output  BUS_W  result beat, valid only while DONE=1, most-significant beat first.
REQ-011 ERROR  output  1  high with DONE when the result is invalid.

Function
REQ-012 FSM states SHALL be LOAD, CALC, OUT.
REQ-013 In LOAD, each cycle with START=1 SHALL shift one beat of A and B into DATA_W registers and increment a beat counter; START=0 cycles SHALL be idle gaps of any length.
REQ-014 On the BEATS-th captured beat, the FSM SHALL enter CALC on the next edge, with the beat counter cleared.
REQ-015 Entering CALC: if operand A==0 or operand B==0, the FSM SHALL skip CALC work, set the error flag, load result 0 and go to OUT on the following edge.
REQ-016 CALC SHALL run binary (Stein) GCD, one step per cycle: both even -> shift both right, k+=1; only a even -> a>>=1; only b even -> b>>=1; both odd and unequal -> larger := larger - smaller; a==b -> result = a<<k, go to OUT.
REQ-017 Shift counter k SHALL be clog2(DATA_W)+1 bits wide; result SHALL be exactly DATA_W bits with no overflow possible.
REQ-018 CALC latency SHALL not exceed 2*DATA_W+2 cycles for any nonzero operands.
REQ-019 OUT SHALL last exactly BEATS cycles: DONE=1, Y = successive result beats MS first, ERROR = error flag; the FSM SHALL then return to LOAD and clear the error flag.
REQ-020 START SHALL be ignored in CALC and OUT; beats presented then SHALL NOT be captured.
REQ-021 A START asserted in the first LOAD cycle after OUT SHALL be captured as beat 0 of the next operation.
REQ-022 Outside OUT, DONE=0, ERROR=0 and Y=0.

Reset
REQ-023 With RST=1 at a rising edge, the block SHALL enter LOAD; BUSY, DONE, ERROR and Y SHALL be 0; beat counter, k, operand registers and error flag SHALL be 0.
REQ-024 Reset in any state, including mid-load, SHALL discard partial operands and any pending result; no DONE SHALL follow for that operation.

Structure
REQ-025 A shared package gcd_pkg SHALL hold the FSM state enum and the default DATA_W/BUS_W constants.
REQ-026 One sub-module, gcd_stein_core, SHALL contain the a/b/k datapath and one-step logic, with the FSM, beat loader and unloader kept in gcd_engine_p.

Verification (DATA_W=16, BUS_W=8)
REQ-027 Beats A=04h,B=20h then A=00h,B=00h with 3 idle cycles between them (1024, 8192) -> DONE for 2 cycles, Y=04h,00h, ERROR=0.
REQ-028 Beats (02h,01h),(06h,03h) (518, 259) -> Y=01h,03h; then beats (01h,00h),(03h,00h) (259, 0) -> Y=00h,00h, ERROR=1 on both DONE cycles.
REQ-029 Operands (0, 0) and (0, 259) -> ERROR=1, Y=0, and DONE no later than 3 cycles after the final load beat.
REQ-030 Operands (46368, 28657) -> Y=00h,01h within 34 cycles of the final load beat; operands (9487, 9487) -> Y=25h,0Fh.
REQ-031 START pulsed during CALC with A=FFh -> ignored, result unchanged; RST asserted after beat 0 -> no DONE, and a fresh 2-beat load then computes correctly.
